// File: rtl/sram_word_bridge_pkg.sv
// -----------------------------------------------------------------------------
// sram_word_bridge_pkg
// Shared definitions for the 32-bit word to 16-bit SRAM bridge:
//   state_e    - bridge FSM states (IDLE, LO half, HI half, read TAIL)
//   LO_HALF    - half-select value for the even (low) half-word address
//   HI_HALF    - half-select value for the odd (high) half-word address
//   half_ce_n  - chip-enable (active-low) for a half given its two byte enables
// -----------------------------------------------------------------------------
package sram_word_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        TAIL = 2'd3
    } state_e;

    localparam logic LO_HALF = 1'b0;
    localparam logic HI_HALF = 1'b1;

    // A half with no enabled byte keeps the chip deselected for its cycle.
    function automatic logic half_ce_n(input logic [1:0] be);
        return ~(be[0] | be[1]);
    endfunction

endpackage

// File: rtl/sram_word_bridge.sv
// -----------------------------------------------------------------------------
// sram_word_bridge
// Splits each 32-bit word access into two 16-bit accesses on a synchronous
// SRAM (read data valid one clk after the read strobe). The low half-word
// lives at the even SRAM address {addr,0}, the high half at {addr,1}.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   req_rd_en, req_wr_en     request strobes (both high = write), held until
//                            req_ready is seen
//   req_addr                 word address (SRAM_ADDR_WIDTH-1 bits)
//   req_wr_data, req_byte_en write word and per-byte enables
//   req_ready                high only while idle and out of reset
//   rsp_valid                one-cycle completion pulse (reads and writes)
//   rsp_rd_data              last read word, held until the next read completes
//   sram_*                   active-low strobes, half-word address and data
// -----------------------------------------------------------------------------
module sram_word_bridge
    import sram_word_bridge_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_DATA_WIDTH = DATA_WIDTH / 2,
    parameter int SRAM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_rd_en,
    input  logic                       req_wr_en,
    input  logic [SRAM_ADDR_WIDTH-2:0] req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wr_data,
    input  logic [3:0]                 req_byte_en,
    output logic                       req_ready,
    output logic                       rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_rd_data,
    output logic                       sram_ce_n,
    output logic                       sram_we_n,
    output logic                       sram_oe_n,
    output logic                       sram_ub_n,
    output logic                       sram_lb_n,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data
);

    state_e                     state_q, state_d;
    logic [SRAM_ADDR_WIDTH-2:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wr_data_q, wr_data_d;
    logic [3:0]                 byte_en_q, byte_en_d;
    logic                       is_wr_q, is_wr_d;

    logic [SRAM_DATA_WIDTH-1:0] rd_lo_q, rd_lo_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]      rsp_rd_data_q, rsp_rd_data_d;

    logic                       sram_ce_n_q, sram_ce_n_d;
    logic                       sram_we_n_q, sram_we_n_d;
    logic                       sram_oe_n_q, sram_oe_n_d;
    logic                       sram_ub_n_q, sram_ub_n_d;
    logic                       sram_lb_n_q, sram_lb_n_d;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DATA_WIDTH-1:0] sram_wr_data_q, sram_wr_data_d;

    logic                       half_sel_s;
    logic [1:0]                 half_be_s;

    // Next-state logic and request capture.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        byte_en_d = byte_en_q;
        is_wr_d   = is_wr_q;
        case (state_q)
            IDLE: begin
                if (req_rd_en || req_wr_en) begin
                    state_d   = LO;
                    addr_d    = req_addr;
                    wr_data_d = req_wr_data;
                    byte_en_d = req_byte_en;
                    is_wr_d   = req_wr_en;   // both strobes high counts as a write
                end else begin
                    state_d   = IDLE;
                end
            end
            LO:      state_d = HI;
            HI: begin
                if (is_wr_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = TAIL;          // one more cycle to collect the high half
                end
            end
            TAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM pins are computed from the upcoming state so they are registered
    // and line up exactly with the LO/HI cycles.
    always_comb begin
        half_sel_s     = LO_HALF;
        half_be_s      = 2'b00;
        sram_ce_n_d    = 1'b1;
        sram_we_n_d    = 1'b1;
        sram_oe_n_d    = 1'b1;
        sram_ub_n_d    = 1'b1;
        sram_lb_n_d    = 1'b1;
        sram_addr_d    = sram_addr_q;
        sram_wr_data_d = {SRAM_DATA_WIDTH{1'b0}};
        case (state_d)
            LO: begin
                half_sel_s = LO_HALF;
                half_be_s  = byte_en_d[1:0];
            end
            HI: begin
                half_sel_s = HI_HALF;
                half_be_s  = byte_en_d[3:2];
            end
            default: begin
                half_sel_s = LO_HALF;
                half_be_s  = 2'b00;
            end
        endcase
        if ((state_d == LO) || (state_d == HI)) begin
            sram_ce_n_d = half_ce_n(half_be_s);
            sram_we_n_d = ~is_wr_d;
            sram_oe_n_d = is_wr_d;
            sram_lb_n_d = ~half_be_s[0];
            sram_ub_n_d = ~half_be_s[1];
            sram_addr_d = {addr_d, half_sel_s};
            if (is_wr_d && (half_sel_s == HI_HALF)) begin
                sram_wr_data_d = wr_data_d[DATA_WIDTH-1:SRAM_DATA_WIDTH];
            end else if (is_wr_d) begin
                sram_wr_data_d = wr_data_d[SRAM_DATA_WIDTH-1:0];
            end else begin
                sram_wr_data_d = {SRAM_DATA_WIDTH{1'b0}};
            end
        end else begin
            sram_ce_n_d    = 1'b1;
            sram_we_n_d    = 1'b1;
            sram_oe_n_d    = 1'b1;
            sram_ub_n_d    = 1'b1;
            sram_lb_n_d    = 1'b1;
            sram_wr_data_d = {SRAM_DATA_WIDTH{1'b0}};
        end
    end

    // Response path: low half arrives during HI, high half during TAIL; the
    // word is published only once complete so rsp_rd_data never shows a mix.
    always_comb begin
        rsp_valid_d   = ((state_q == HI) && is_wr_q) || (state_q == TAIL);
        rd_lo_d       = ((state_q == HI) && !is_wr_q) ? sram_rd_data : rd_lo_q;
        rsp_rd_data_d = (state_q == TAIL) ? {sram_rd_data, rd_lo_q} : rsp_rd_data_q;
    end

    // State, request and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= {(SRAM_ADDR_WIDTH-1){1'b0}};
            wr_data_q      <= {DATA_WIDTH{1'b0}};
            byte_en_q      <= 4'b0000;
            is_wr_q        <= 1'b0;
            rd_lo_q        <= {SRAM_DATA_WIDTH{1'b0}};
            rsp_valid_q    <= 1'b0;
            rsp_rd_data_q  <= {DATA_WIDTH{1'b0}};
            sram_ce_n_q    <= 1'b1;
            sram_we_n_q    <= 1'b1;
            sram_oe_n_q    <= 1'b1;
            sram_ub_n_q    <= 1'b1;
            sram_lb_n_q    <= 1'b1;
            sram_addr_q    <= {SRAM_ADDR_WIDTH{1'b0}};
            sram_wr_data_q <= {SRAM_DATA_WIDTH{1'b0}};
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wr_data_q      <= wr_data_d;
            byte_en_q      <= byte_en_d;
            is_wr_q        <= is_wr_d;
            rd_lo_q        <= rd_lo_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rd_data_q  <= rsp_rd_data_d;
            sram_ce_n_q    <= sram_ce_n_d;
            sram_we_n_q    <= sram_we_n_d;
            sram_oe_n_q    <= sram_oe_n_d;
            sram_ub_n_q    <= sram_ub_n_d;
            sram_lb_n_q    <= sram_lb_n_d;
            sram_addr_q    <= sram_addr_d;
            sram_wr_data_q <= sram_wr_data_d;
        end
    end

    assign req_ready    = (state_q == IDLE) && !rst;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rd_data  = rsp_rd_data_q;
    // Reset also deselects the chip at once, so a half still in flight when
    // reset arrives is never written.
    assign sram_ce_n    = sram_ce_n_q | rst;
    assign sram_we_n    = sram_we_n_q;
    assign sram_oe_n    = sram_oe_n_q;
    assign sram_ub_n    = sram_ub_n_q;
    assign sram_lb_n    = sram_lb_n_q;
    assign sram_addr    = sram_addr_q;
    assign sram_wr_data = sram_wr_data_q;

endmodule

// File: tb/tb_sram_word_bridge.sv
module tb_sram_word_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd_en, req_wr_en;
    logic [8:0]  req_addr;
    logic [31:0] req_wr_data;
    logic [3:0]  req_byte_en;
    logic        req_ready, rsp_valid;
    logic [31:0] rsp_rd_data;
    logic        sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
    logic [9:0]  sram_addr;
    logic [15:0] sram_wr_data, sram_rd_data;

    sram_word_bridge dut (
        .clk(clk), .rst(rst),
        .req_rd_en(req_rd_en), .req_wr_en(req_wr_en), .req_addr(req_addr),
        .req_wr_data(req_wr_data), .req_byte_en(req_byte_en),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data),
        .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .sram_addr(sram_addr),
        .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model: byte-lane writes, read data one clk after strobe.
    logic [15:0] mem [0:1023];
    logic        mem_clear;
    int          wr_cnt = 0;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
        end else if (!sram_ce_n) begin
            if (!sram_we_n) begin
                wr_cnt <= wr_cnt + 1;
                if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_wr_data[7:0];
                if (!sram_ub_n) mem[sram_addr][15:8] <= sram_wr_data[15:8];
            end
            if (!sram_oe_n) sram_rd_data <= mem[sram_addr];
        end
    end

    // Word-level reference: a plain array of 32-bit words plus the last read.
    logic [31:0] ref_mem [0:511];
    logic [31:0] last_rd;

    int n_tests = 0;
    int n_fail  = 0;

    // Pin snapshots taken during the LO (first) and HI (second) cycles.
    logic [9:0]  lo_addr, hi_addr;
    logic        lo_ce, hi_ce, lo_we, hi_lb, hi_ub;
    logic [15:0] hi_wd;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [8:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_rsp;
        int          exp_lat;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour: apply byte enables to the word, or return the word.
    task automatic model_op(input logic wr, input logic [8:0] a, input logic [31:0] d,
                            input logic [3:0] be, output logic [31:0] exp_rsp);
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
        end else begin
            last_rd = ref_mem[a];
        end
        exp_rsp = last_rd;
    endtask

    // Issue one request at a negedge; returns at the negedge where rsp_valid is seen.
    task automatic do_op(input logic wr, input logic rd, input logic [8:0] a,
                         input logic [31:0] d, input logic [3:0] be, output int lat);
        int k;
        int w;
        req_wr_en = wr; req_rd_en = rd; req_addr = a; req_wr_data = d; req_byte_en = be;
        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        req_wr_en = 1'b0; req_rd_en = 1'b0;
        k = 1;
        while (!rsp_valid && k < 10) begin
            if (k == 1) begin
                lo_addr = sram_addr; lo_ce = sram_ce_n; lo_we = sram_we_n;
            end
            if (k == 2) begin
                hi_addr = sram_addr; hi_ce = sram_ce_n; hi_lb = sram_lb_n;
                hi_ub = sram_ub_n; hi_wd = sram_wr_data;
            end
            @(negedge clk);
            k++;
        end
        lat = rsp_valid ? k : 99;
    endtask

    task automatic check_op(input string tag, input logic wr, input logic [8:0] a,
                            input logic [31:0] d, input logic [3:0] be, input int lat,
                            input logic [31:0] exp_rsp, input int exp_lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, rsp_rd_data, exp_rsp);
        chk({tag, "_lo_addr"}, 32'(lo_addr), 32'({a, 1'b0}));
        chk({tag, "_hi_addr"}, 32'(hi_addr), 32'({a, 1'b1}));
        chk({tag, "_lo_ce"}, 32'(lo_ce), 32'(be[1:0] == 2'b00));
        chk({tag, "_hi_ce"}, 32'(hi_ce), 32'(be[3:2] == 2'b00));
        chk({tag, "_we"}, 32'(lo_we), 32'(!wr));
        chk({tag, "_hi_lb"}, 32'(hi_lb), 32'(!be[2]));
        chk({tag, "_hi_ub"}, 32'(hi_ub), 32'(!be[3]));
        if (wr) begin
            chk({tag, "_hi_wd"}, 32'(hi_wd), 32'(d[31:16]));
            chk({tag, "_mem"}, {mem[{a, 1'b1}], mem[{a, 1'b0}]}, ref_mem[a]);
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int wr0;
        logic [31:0] exp_rsp;
        logic        wr, rd;
        logic [8:0]  a;
        logic [31:0] d;
        logic [3:0]  be;

        tbl[0] = '{1'b1, 1'b0, 9'd5, 32'hDEADBEEF, 4'hF, 32'h00000000, 3};
        tbl[1] = '{1'b0, 1'b1, 9'd5, 32'h00000000, 4'hF, 32'hDEADBEEF, 4};
        tbl[2] = '{1'b1, 1'b0, 9'd5, 32'h00AA0000, 4'h4, 32'hDEADBEEF, 3};
        tbl[3] = '{1'b0, 1'b1, 9'd5, 32'h00000000, 4'hF, 32'hDEAABEEF, 4};
        tbl[4] = '{1'b1, 1'b1, 9'd7, 32'h12345678, 4'hF, 32'hDEAABEEF, 3};
        tbl[5] = '{1'b0, 1'b1, 9'd7, 32'h00000000, 4'hF, 32'h12345678, 4};
        tbl[6] = '{1'b1, 1'b0, 9'd0, 32'hA5A55A5A, 4'h3, 32'h12345678, 3};
        tbl[7] = '{1'b0, 1'b1, 9'd0, 32'h00000000, 4'hF, 32'h00005A5A, 4};
        tbl[8] = '{1'b1, 1'b0, 9'd1, 32'hCAFEF00D, 4'h0, 32'h00005A5A, 3};
        tbl[9] = '{1'b0, 1'b1, 9'd1, 32'h00000000, 4'hF, 32'h00000000, 4};

        for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
        last_rd = 32'h0;
        rst = 1'b1; mem_clear = 1'b1;
        req_rd_en = 1'b0; req_wr_en = 1'b0; req_addr = 9'd0;
        req_wr_data = 32'h0; req_byte_en = 4'h0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rd_data, 32'h0);
        chk("rst_strobes", 32'({sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'h1F);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_wdata", 32'(sram_wr_data), 32'd0);
        rst = 1'b0; mem_clear = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].be, lat);
            model_op(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].be, exp_rsp);
            chk($sformatf("vec%0d_table_rsp", i), exp_rsp, tbl[i].exp_rsp);
            check_op($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].data,
                     tbl[i].be, lat, tbl[i].exp_rsp, tbl[i].exp_lat);
        end
        chk("sram10", 32'(mem[10]), 32'h0000BEEF);
        chk("sram11", 32'(mem[11]), 32'h0000DEAA);

        // Write strobe held through the busy cycles: exactly one write.
        wr0 = wr_cnt; pulses = 0;
        req_wr_en = 1'b1; req_addr = 9'd3; req_wr_data = 32'h0BADF00D; req_byte_en = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                pulses++;
                req_wr_en = 1'b0;
            end
        end
        model_op(1'b1, 9'd3, 32'h0BADF00D, 4'hF, exp_rsp);
        chk("hold_pulses", 32'(pulses), 32'd1);
        chk("hold_half_writes", 32'(wr_cnt - wr0), 32'd2);
        chk("hold_mem", {mem[7], mem[6]}, ref_mem[3]);

        // Reset during the HI cycle of a write aborts it.
        req_wr_en = 1'b1; req_addr = 9'd9; req_wr_data = 32'h11112222; req_byte_en = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_ready_in_rst", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("abort_strobes", 32'({sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'h1F);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_lo_written", 32'(mem[18]), 32'h2222);
        chk("abort_hi_not_written", 32'(mem[19]), 32'h0000);
        rst = 1'b0;
        ref_mem[9][15:0] = 16'h2222;
        last_rd = 32'h0;
        @(negedge clk);
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        chk("abort_rdata_cleared", rsp_rd_data, 32'h0);

        // Back-to-back at the top word address.
        do_op(1'b1, 1'b0, 9'd511, 32'h13579BDF, 4'hF, lat);
        model_op(1'b1, 9'd511, 32'h13579BDF, 4'hF, exp_rsp);
        check_op("b2b_wr", 1'b1, 9'd511, 32'h13579BDF, 4'hF, lat, exp_rsp, 3);
        chk("b2b_ready_in_rsp", 32'(req_ready), 32'd1);
        do_op(1'b0, 1'b1, 9'd511, 32'h0, 4'hF, lat);
        model_op(1'b0, 9'd511, 32'h0, 4'hF, exp_rsp);
        check_op("b2b_rd", 1'b0, 9'd511, 32'h0, 4'hF, lat, exp_rsp, 4);
        chk("b2b_top_addr", 32'(hi_addr), 32'h3FF);
        @(negedge clk);
        chk("b2b_pulse_width", 32'(rsp_valid), 32'd0);

        // Randomized traffic against the word model.
        for (int i = 0; i < 150; i++) begin
            a  = ($urandom_range(0, 3) == 0) ? 9'd511 : 9'($urandom_range(0, 15));
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            d  = $urandom;
            be = wr ? 4'($urandom_range(0, 15)) : 4'hF;
            do_op(wr, rd, a, d, be, lat);
            model_op(wr, a, d, be, exp_rsp);
            check_op($sformatf("rnd%0d", i), wr, a, d, be, lat, exp_rsp, wr ? 3 : 4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
